pos_update_arbiter: RTL and testbench

Frame-synchronous position-update arbiter for the VGA draw pipeline. Two requesters (local mouse/player logic and remote/AI logic) share one write port into a pair of position registers that feed the draw stages alongside the delayed timing signals. Updates are committed only during vertical blanking, so coordinates stay stable for every visible line of a frame. Grants use a round-robin policy and a once-per-frame quota per requester.

---
 rtl/pos_arb_pkg.sv | 14 +
 rtl/pos_update_arbiter_rr_pick2.sv | 15 +
 rtl/pos_update_arbiter.sv | 134 +++++++++++++
 tb/tb_pos_update_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pos_arb_pkg.sv
// Shared types and constants for the frame-synchronous position-update arbiter.
// Holds the coordinate width default, the requester count and the FSM state encoding.
package pos_arb_pkg;

   localparam int POS_W_DEFAULT = 12;
   localparam int NUM_REQ       = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARB    = 2'd1,
      COMMIT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/pos_update_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone pending bit wins outright; a tie goes to rr.
// Purely combinational; the pointer itself lives in the top level.
module rr_pick2 (
   input  logic [1:0] pending,
   input  logic       rr,
   output logic       winner,
   output logic       any
);

   always_comb begin
      any    = |pending;
      winner = (pending == 2'b11) ? rr : pending[1];
   end

endmodule

// File: rtl/pos_update_arbiter.sv
// Commits requester positions into two slots only during vertical blanking,
// with a round-robin tie break and at most one commit per requester per frame.
module pos_update_arbiter
   import pos_arb_pkg::*;
#(
   parameter int POS_W = POS_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vblnk,
   input  logic [1:0]         req,
   input  logic [POS_W-1:0]   xpos0,
   input  logic [POS_W-1:0]   ypos0,
   input  logic [POS_W-1:0]   xpos1,
   input  logic [POS_W-1:0]   ypos1,
   output logic [1:0]         ack,
   output logic [POS_W-1:0]   xpos_out0,
   output logic [POS_W-1:0]   ypos_out0,
   output logic [POS_W-1:0]   xpos_out1,
   output logic [POS_W-1:0]   ypos_out1,
   output logic [1:0]         pos_valid,
   output logic               frame_tick,
   output logic [1:0]         state_dbg
);

   // Handshake: a requester holds req and its coordinates until it sees ack;
   // ack is a one-cycle strobe and the data is captured on the edge raising it.

   arb_state_t           state_q, state_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   served_q, served_d;
   logic [NUM_REQ-1:0]   pos_valid_q, pos_valid_d;
   logic                 rr_q, rr_d;
   logic                 vblnk_d_q, vblnk_d_d;
   logic                 frame_tick_q, frame_tick_d;
   logic [POS_W-1:0]     x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;

   logic                 rise;
   logic [NUM_REQ-1:0]   pending;
   logic                 winner;
   logic                 any;

   assign rise    = vblnk & ~vblnk_d_q;
   assign pending = req & ~served_q;

   rr_pick2 u_pick (
      .pending (pending),
      .rr      (rr_q),
      .winner  (winner),
      .any     (any)
   );

   always_comb begin
      state_d      = state_q;
      ack_d        = '0;
      served_d     = served_q;
      pos_valid_d  = pos_valid_q;
      rr_d         = rr_q;
      vblnk_d_d    = vblnk;
      frame_tick_d = rise;
      x0_d         = x0_q;
      y0_d         = y0_q;
      x1_d         = x1_q;
      y1_d         = y1_q;

      // A blank rising edge restarts the frame's quota regardless of state.
      if (rise) begin
         served_d = '0;
         state_d  = ARB;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            ARB: begin
               if (!vblnk) begin
                  state_d = IDLE;
               end else if (any) begin
                  if (winner) begin
                     x1_d = xpos1;
                     y1_d = ypos1;
                  end else begin
                     x0_d = xpos0;
                     y0_d = ypos0;
                  end
                  ack_d[winner]       = 1'b1;
                  served_d[winner]    = 1'b1;
                  pos_valid_d[winner] = 1'b1;
                  rr_d                = ~winner;
                  state_d             = COMMIT;
               end
            end
            COMMIT:  state_d = vblnk ? ARB : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ack_q        <= '0;
         served_q     <= '0;
         pos_valid_q  <= '0;
         rr_q         <= 1'b0;
         vblnk_d_q    <= 1'b1;
         frame_tick_q <= 1'b0;
         x0_q         <= '0;
         y0_q         <= '0;
         x1_q         <= '0;
         y1_q         <= '0;
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         served_q     <= served_d;
         pos_valid_q  <= pos_valid_d;
         rr_q         <= rr_d;
         vblnk_d_q    <= vblnk_d_d;
         frame_tick_q <= frame_tick_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         x1_q         <= x1_d;
         y1_q         <= y1_d;
      end
   end

   assign ack        = ack_q;
   assign pos_valid  = pos_valid_q;
   assign frame_tick = frame_tick_q;
   assign xpos_out0  = x0_q;
   assign ypos_out0  = y0_q;
   assign xpos_out1  = x1_q;
   assign ypos_out1  = y1_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_pos_update_arbiter.sv
// Directed cycle table for pos_update_arbiter: each row is the inputs before an
// edge and the outputs expected just after it, plus a mid-commit reset sequence.
module tb_pos_update_arbiter;
   import pos_arb_pkg::*;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst;
   logic         vblnk;
   logic [1:0]   req;
   logic [W-1:0] xpos0, ypos0, xpos1, ypos1;
   logic [1:0]   ack;
   logic [W-1:0] xpos_out0, ypos_out0, xpos_out1, ypos_out1;
   logic [1:0]   pos_valid;
   logic         frame_tick;
   logic [1:0]   state_dbg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         v;
      logic [1:0]   rq;
      logic [W-1:0] x0, y0, x1, y1;
      logic [1:0]   e_ack;
      logic [W-1:0] e_x0, e_y0, e_x1, e_y1;
      logic [1:0]   e_pv;
      logic         e_ft;
   } row_t;

   row_t rows[$];

   pos_update_arbiter #(.POS_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .vblnk      (vblnk),
      .req        (req),
      .xpos0      (xpos0),
      .ypos0      (ypos0),
      .xpos1      (xpos1),
      .ypos1      (ypos1),
      .ack        (ack),
      .xpos_out0  (xpos_out0),
      .ypos_out0  (ypos_out0),
      .xpos_out1  (xpos_out1),
      .ypos_out1  (ypos_out1),
      .pos_valid  (pos_valid),
      .frame_tick (frame_tick),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [1:0] rq,
                      input int x0, input int y0, input int x1, input int y1,
                      input logic [1:0] e_ack,
                      input int e_x0, input int e_y0, input int e_x1, input int e_y1,
                      input logic [1:0] e_pv, input logic e_ft);
      row_t r;
      r.v = v; r.rq = rq;
      r.x0 = W'(x0); r.y0 = W'(y0); r.x1 = W'(x1); r.y1 = W'(y1);
      r.e_ack = e_ack;
      r.e_x0 = W'(e_x0); r.e_y0 = W'(e_y0); r.e_x1 = W'(e_x1); r.e_y1 = W'(e_y1);
      r.e_pv = e_pv; r.e_ft = e_ft;
      rows.push_back(r);
   endtask

   task automatic check_outs(input string tag, input logic [1:0] e_ack,
                             input logic [W-1:0] e_x0, input logic [W-1:0] e_y0,
                             input logic [W-1:0] e_x1, input logic [W-1:0] e_y1,
                             input logic [1:0] e_pv, input logic e_ft);
      check({tag, ".ack"},        32'(ack),        32'(e_ack));
      check({tag, ".xpos_out0"},  32'(xpos_out0),  32'(e_x0));
      check({tag, ".ypos_out0"},  32'(ypos_out0),  32'(e_y0));
      check({tag, ".xpos_out1"},  32'(xpos_out1),  32'(e_x1));
      check({tag, ".ypos_out1"},  32'(ypos_out1),  32'(e_y1));
      check({tag, ".pos_valid"},  32'(pos_valid),  32'(e_pv));
      check({tag, ".frame_tick"}, 32'(frame_tick), 32'(e_ft));
   endtask

   initial begin
      logic [1:0] idle_code;
      logic [1:0] arb_code;
      idle_code = IDLE;
      arb_code  = ARB;

      //   v  req  x0  y0  x1  y1 | ack  ox0 oy0 ox1 oy1 pv  ft
      // reset released inside blank: no tick, no grant
      add(1, 2'b11,   5,   6,   7,   8, 2'b00,   0,   0,  0,  0, 2'b00, 0);
      add(1, 2'b11,   5,   6,   7,   8, 2'b00,   0,   0,  0,  0, 2'b00, 0);
      add(0, 2'b00,   5,   6,   7,   8, 2'b00,   0,   0,  0,  0, 2'b00, 0);
      add(0, 2'b01, 320, 240,   7,   8, 2'b00,   0,   0,  0,  0, 2'b00, 0);
      // single requester 0 frame
      add(1, 2'b01, 320, 240,   7,   8, 2'b00,   0,   0,  0,  0, 2'b00, 1);
      add(1, 2'b01, 320, 240,   7,   8, 2'b01, 320, 240,  0,  0, 2'b01, 0);
      add(1, 2'b00, 320, 240,   7,   8, 2'b00, 320, 240,  0,  0, 2'b01, 0);
      add(1, 2'b01, 100, 101,   7,   8, 2'b00, 320, 240,  0,  0, 2'b01, 0);
      add(0, 2'b00, 100, 101,   7,   8, 2'b00, 320, 240,  0,  0, 2'b01, 0);
      // both request, pointer now favours requester 1
      add(1, 2'b11,  11,  12,  21,  22, 2'b00, 320, 240,  0,  0, 2'b01, 1);
      add(1, 2'b11,  11,  12,  21,  22, 2'b10, 320, 240, 21, 22, 2'b11, 0);
      add(1, 2'b11,  11,  12,  21,  22, 2'b00, 320, 240, 21, 22, 2'b11, 0);
      add(1, 2'b11,  11,  12,  21,  22, 2'b01,  11,  12, 21, 22, 2'b11, 0);
      add(1, 2'b11,  11,  12,  21,  22, 2'b00,  11,  12, 21, 22, 2'b11, 0);
      add(1, 2'b11,  99,  98,  97,  96, 2'b00,  11,  12, 21, 22, 2'b11, 0);
      // active video with held requests and changing data
      add(0, 2'b11, 500, 501, 600, 601, 2'b00,  11,  12, 21, 22, 2'b11, 0);
      add(0, 2'b11, 502, 503, 602, 603, 2'b00,  11,  12, 21, 22, 2'b11, 0);
      // requester 1 alone
      add(1, 2'b10, 502, 503,  30,  31, 2'b00,  11,  12, 21, 22, 2'b11, 1);
      add(1, 2'b10, 502, 503,  30,  31, 2'b10,  11,  12, 30, 31, 2'b11, 0);
      add(1, 2'b00, 502, 503,  30,  31, 2'b00,  11,  12, 30, 31, 2'b11, 0);
      add(0, 2'b00, 502, 503,  30,  31, 2'b00,  11,  12, 30, 31, 2'b11, 0);
      // both, pointer back at 0; blank ends right after first grant
      add(1, 2'b11,  40,  41,  50,  51, 2'b00,  11,  12, 30, 31, 2'b11, 1);
      add(1, 2'b11,  40,  41,  50,  51, 2'b01,  40,  41, 30, 31, 2'b11, 0);
      add(0, 2'b11,  40,  41,  50,  51, 2'b00,  40,  41, 30, 31, 2'b11, 0);
      // blank drops on the edge a grant would occur
      add(1, 2'b00,  40,  41,  50,  51, 2'b00,  40,  41, 30, 31, 2'b11, 1);
      add(0, 2'b11,  60,  61,  70,  71, 2'b00,  40,  41, 30, 31, 2'b11, 0);
      add(0, 2'b11,  60,  61,  70,  71, 2'b00,  40,  41, 30, 31, 2'b11, 0);
      // requests from active video served after the next rise
      add(1, 2'b11,  60,  61,  70,  71, 2'b00,  40,  41, 30, 31, 2'b11, 1);
      add(1, 2'b11,  60,  61,  70,  71, 2'b10,  40,  41, 70, 71, 2'b11, 0);
      add(1, 2'b11,  60,  61,  70,  71, 2'b00,  40,  41, 70, 71, 2'b11, 0);
      add(1, 2'b11,  60,  61,  70,  71, 2'b01,  60,  61, 70, 71, 2'b11, 0);

      rst = 1'b1; vblnk = 1'b1; req = 2'b11;
      xpos0 = W'(5); ypos0 = W'(6); xpos1 = W'(7); ypos1 = W'(8);
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
      check("reset.state", 32'(state_dbg), 32'(idle_code));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < rows.size(); i++) begin
         @(negedge clk);
         vblnk = rows[i].v;   req   = rows[i].rq;
         xpos0 = rows[i].x0;  ypos0 = rows[i].y0;
         xpos1 = rows[i].x1;  ypos1 = rows[i].y1;
         @(posedge clk);
         #1;
         check_outs($sformatf("row%0d", i), rows[i].e_ack, rows[i].e_x0, rows[i].e_y0,
                    rows[i].e_x1, rows[i].e_y1, rows[i].e_pv, rows[i].e_ft);
      end

      // Last row left the FSM in COMMIT with ack high; reset asynchronously mid-cycle.
      check("precommit.state", 32'(state_dbg), 32'(COMMIT));
      #2;
      rst = 1'b1;
      #1;
      check_outs("async_rst", 2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
      check("async_rst.state", 32'(state_dbg), 32'(idle_code));
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         check_outs("post_rst_blank", 2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
      end
      @(negedge clk);
      vblnk = 1'b0;
      @(negedge clk);
      vblnk = 1'b1;
      @(posedge clk);
      #1;
      check_outs("post_rst_rise", 2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
      check("post_rst_rise.state", 32'(state_dbg), 32'(arb_code));
      @(posedge clk);
      #1;
      check_outs("post_rst_grant", 2'b01, W'(60), W'(61), '0, '0, 2'b01, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
